// File: rtl/keyboard_event_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : keyboard_event_rx
// Function : PS/2 keyboard receiver folding E0/F0 prefixes into key events,
//            queued in a first-word-fall-through FIFO with a valid/ready port.
// Revision : 1.0
// ============================================================================
module keyboard_event_rx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int REPORT_BREAK   = 0,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                        CLK,
  input  logic                        RESETn,
  input  logic                        ps2_clk,
  input  logic                        ps2_data,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [7:0]                  evt_code,
  output logic                        evt_break,
  output logic                        evt_ext,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  input  logic                        clear_overflow,
  output logic                        parity_err,
  input  logic                        flush
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] c_tmo_last = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0]   c_full     = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_clk_prev;
  logic                   w_ps2_clk;
  logic                   w_ps2_data;
  logic                   w_edge;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [2:0]     r_bit_idx;
  logic [7:0]     r_shift;
  logic           r_parity;
  logic [TW-1:0]  r_tmo_cnt;
  logic           w_timeout;
  logic           w_frame_done;
  logic           w_good;
  logic           w_good_frame;
  logic           w_bad_frame;
  logic           r_parity_err;

  logic           r_ext;
  logic           r_brk;
  logic           w_ext_nxt;
  logic           w_brk_nxt;
  logic           w_push;
  logic [9:0]     w_push_data;

  logic [9:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           r_overflow;
  logic           w_full;
  logic           w_pop;
  logic           w_wr_en;
  logic           w_drop;
  logic [9:0]     w_head;

  // Synchronisers idle high so a reset never fabricates a falling edge.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
      r_clk_prev  <= w_ps2_clk;
    end
  end

  assign w_ps2_clk  = r_clk_sync[SYNC_STAGES-1];
  assign w_ps2_data = r_data_sync[SYNC_STAGES-1];
  assign w_edge     = r_clk_prev & ~w_ps2_clk;

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_frame_done = 1'b0;
    case (r_state)
      S_IDLE:   if (w_edge && !w_ps2_data) w_state_nxt = S_DATA;
      S_DATA:   if (w_edge && r_bit_idx == 3'd7) w_state_nxt = S_PARITY;
      S_PARITY: if (w_edge) w_state_nxt = S_STOP;
      S_STOP: begin
        if (w_edge) begin
          w_state_nxt  = S_IDLE;
          w_frame_done = 1'b1;
        end
      end
      default:  w_state_nxt = S_IDLE;
    endcase
    if (w_timeout) w_state_nxt = S_IDLE;
  end

  assign w_timeout = (r_state != S_IDLE) & ~w_edge & (r_tmo_cnt == c_tmo_last);

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_IDLE || w_edge || w_timeout) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
    end else if (w_edge) begin
      case (r_state)
        S_IDLE: r_bit_idx <= '0;
        S_DATA: begin
          r_shift   <= {w_ps2_data, r_shift[7:1]};
          r_bit_idx <= r_bit_idx + 3'd1;
        end
        S_PARITY: r_parity <= w_ps2_data;
        default: ;
      endcase
    end
  end

  // The stop bit is the live data sample at the closing edge.
  assign w_good       = w_ps2_data & (^r_shift ^ r_parity);
  assign w_good_frame = w_frame_done & w_good;
  assign w_bad_frame  = w_frame_done & ~w_good;

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_bad_frame;
    end
  end

  always_comb begin
    w_ext_nxt = r_ext;
    w_brk_nxt = r_brk;
    w_push    = 1'b0;
    if (flush || w_bad_frame) begin
      w_ext_nxt = 1'b0;
      w_brk_nxt = 1'b0;
    end else if (w_good_frame) begin
      if (r_shift == 8'hE0) begin
        w_ext_nxt = 1'b1;
      end else if (r_shift == 8'hF0) begin
        w_brk_nxt = 1'b1;
      end else begin
        w_ext_nxt = 1'b0;
        w_brk_nxt = 1'b0;
        w_push    = (REPORT_BREAK != 0) || !r_brk;
      end
    end
  end

  assign w_push_data = {r_ext, r_brk, r_shift};

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else begin
      r_ext <= w_ext_nxt;
      r_brk <= w_brk_nxt;
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_full  = (r_count == c_full);
  assign w_pop   = evt_valid & evt_ready;
  assign w_wr_en = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;

  always_ff @(posedge CLK) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge CLK) begin
    if (!RESETn || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clear_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign w_head     = r_mem[r_rd_ptr];
  assign evt_valid  = (r_count != '0);
  assign evt_code   = evt_valid ? w_head[7:0] : 8'h00;
  assign evt_break  = evt_valid & w_head[8];
  assign evt_ext    = evt_valid & w_head[9];
  assign fifo_count = r_count;
  assign overflow   = r_overflow;
  assign parity_err = r_parity_err;

endmodule
`default_nettype wire

// File: tb/tb_keyboard_event_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_keyboard_event_rx
// Function : Directed scoreboard bench for keyboard_event_rx.
// Revision : 1.0
// ============================================================================
module tb_keyboard_event_rx;

  localparam int c_depth = 8;
  localparam int c_tmo   = 100;

  logic       CLK = 1'b0;
  logic       RESETn, ps2_clk, ps2_data, evt_ready, clear_overflow, flush;
  logic       evt_valid, evt_break, evt_ext, overflow, parity_err;
  logic [7:0] evt_code;
  logic [3:0] fifo_count;
  logic       d0_valid, d0_break, d0_ext, d0_overflow, d0_parity_err;
  logic [7:0] d0_code;
  logic [3:0] d0_count;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } evt_t;

  evt_t sb_q[$];
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   n_perr = 0;
  int   perr_snap;

  always #5 CLK = ~CLK;

  keyboard_event_rx #(
    .FIFO_DEPTH(c_depth), .TIMEOUT_CYCLES(c_tmo), .REPORT_BREAK(1), .SYNC_STAGES(2)
  ) dut (
    .CLK(CLK), .RESETn(RESETn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_break(evt_break), .evt_ext(evt_ext), .fifo_count(fifo_count),
    .overflow(overflow), .clear_overflow(clear_overflow),
    .parity_err(parity_err), .flush(flush)
  );

  // Companion instance that drops key-release events.
  keyboard_event_rx #(
    .FIFO_DEPTH(c_depth), .TIMEOUT_CYCLES(c_tmo), .REPORT_BREAK(0), .SYNC_STAGES(2)
  ) dut0 (
    .CLK(CLK), .RESETn(RESETn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .evt_valid(d0_valid), .evt_ready(evt_ready), .evt_code(d0_code),
    .evt_break(d0_break), .evt_ext(d0_ext), .fifo_count(d0_count),
    .overflow(d0_overflow), .clear_overflow(clear_overflow),
    .parity_err(d0_parity_err), .flush(flush)
  );

  always @(posedge CLK) if (parity_err) n_perr <= n_perr + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    cyc(4);
    ps2_clk = 1'b0;
    cyc(8);
    ps2_clk = 1'b1;
    cyc(4);
  endtask

  task automatic frame_head(input logic [7:0] c, input logic badpar);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(c[i]);
    ps2_bit(~(^c) ^ badpar);
  endtask

  task automatic stop_fall();
    ps2_data = 1'b1;
    cyc(4);
    ps2_clk = 1'b0;
  endtask

  task automatic stop_rise();
    cyc(8);
    ps2_clk = 1'b1;
    cyc(4);
  endtask

  task automatic send(input logic [7:0] c);
    frame_head(c, 1'b0);
    stop_fall();
    stop_rise();
  endtask

  task automatic expect_evt(input logic ext, input logic brk, input logic [7:0] code);
    evt_t e;
    e.ext  = ext;
    e.brk  = brk;
    e.code = code;
    sb_q.push_back(e);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
  endtask

  task automatic drain_one(input string tag);
    evt_t e;
    int   t = 0;
    while (!evt_valid && t < 50) begin
      cyc(1);
      t++;
    end
    chk({tag, "-valid"}, 32'(evt_valid), 32'd1);
    chk({tag, "-sb"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, "-evt"}, 32'({evt_ext, evt_break, evt_code}), 32'(e));
    end
    evt_ready = 1'b1;
    cyc(1);
    evt_ready = 1'b0;
  endtask

  initial begin
    RESETn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    evt_ready = 1'b0; clear_overflow = 1'b0; flush = 1'b0;
    cyc(5);
    chk("rst-valid", 32'(evt_valid), 32'd0);
    chk("rst-code", 32'(evt_code), 32'd0);
    chk("rst-break", 32'(evt_break), 32'd0);
    chk("rst-ext", 32'(evt_ext), 32'd0);
    chk("rst-count", 32'(fifo_count), 32'd0);
    chk("rst-ovf", 32'(overflow), 32'd0);
    chk("rst-perr", 32'(parity_err), 32'd0);
    RESETn = 1'b1;
    cyc(2);

    // Single make code; event appears the cycle after the stop edge is seen.
    frame_head(8'h1C, 1'b0);
    expect_evt(1'b0, 1'b0, 8'h1C);
    stop_fall();
    cyc(2);
    chk("lat-early", 32'(evt_valid), 32'd0);
    cyc(1);
    chk("lat-valid", 32'(evt_valid), 32'd1);
    chk("lat-count", 32'(fifo_count), 32'd1);
    stop_rise();
    drain_one("t1");
    chk("t1-count", 32'(fifo_count), 32'd0);
    chk("t1-valid", 32'(evt_valid), 32'd0);

    // Break sequence: kept with REPORT_BREAK=1, dropped with 0.
    pulse_flush();
    send(8'hF0);
    send(8'h1C);
    expect_evt(1'b0, 1'b1, 8'h1C);
    cyc(2);
    chk("brk-d0-count", 32'(d0_count), 32'd0);
    chk("brk-count", 32'(fifo_count), 32'd1);
    drain_one("brk");

    // Extended release, then a plain make of the same code.
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    send(8'h75);
    expect_evt(1'b1, 1'b1, 8'h75);
    expect_evt(1'b0, 1'b0, 8'h75);
    chk("ext-count", 32'(fifo_count), 32'd2);
    chk("ext-d0-count", 32'(d0_count), 32'd1);
    drain_one("ext1");
    drain_one("ext2");

    // Bad parity: one-cycle error pulse, no event.
    frame_head(8'h1C, 1'b1);
    stop_fall();
    cyc(2);
    chk("perr-pre", 32'(parity_err), 32'd0);
    cyc(1);
    chk("perr-pulse", 32'(parity_err), 32'd1);
    cyc(1);
    chk("perr-post", 32'(parity_err), 32'd0);
    stop_rise();
    chk("perr-count", 32'(fifo_count), 32'd0);
    send(8'h32);
    expect_evt(1'b0, 1'b0, 8'h32);
    drain_one("post-perr");

    // Overflow: nine frames into an eight-entry FIFO.
    pulse_flush();
    for (int c = 8'h15; c <= 8'h1D; c++) begin
      send(8'(c));
      if (c <= 8'h1C) expect_evt(1'b0, 1'b0, 8'(c));
    end
    chk("ovf-count", 32'(fifo_count), 32'd8);
    chk("ovf-flag", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) drain_one("ovf-drain");
    chk("ovf-empty", 32'(fifo_count), 32'd0);
    chk("ovf-sticky", 32'(overflow), 32'd1);
    clear_overflow = 1'b1;
    cyc(1);
    clear_overflow = 1'b0;
    chk("ovf-clear", 32'(overflow), 32'd0);

    // Partial frame abandoned by the timeout, then a clean frame.
    perr_snap = n_perr;
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_data = 1'b1;
    cyc(c_tmo + 10);
    chk("tmo-count", 32'(fifo_count), 32'd0);
    chk("tmo-perr", 32'(n_perr - perr_snap), 32'd0);
    send(8'h24);
    expect_evt(1'b0, 1'b0, 8'h24);
    drain_one("tmo-next");
    chk("sb-empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keyboard_event_rx.md
Name: keyboard_event_rx

Overview:
Parametrised PS/2 keyboard receiver and successor to the single-byte keyboard buffer. It synchronises the PS/2 lines, deframes 11-bit frames and checks start, odd parity and stop bits. It folds E0 (extended) and F0 (break) prefixes into one event per key and queues events in a first-word-fall-through FIFO with a valid/ready read port. It sits between the keyboard pins and the CPU I/O register and replaces the one-deep clear-on-read buffer.

Parameters:
FIFO_DEPTH, 8, event FIFO entries; power of two, at least 2.
TIMEOUT_CYCLES, 50000, CLK cycles without a PS/2 falling edge before a partial frame is discarded.
REPORT_BREAK, 0, 1 = queue key-release events; 0 = drop them.
SYNC_STAGES, 2, synchroniser flops on ps2_clk and ps2_data; at least 2.

Ports:
CLK  in  1  system clock; all logic on its rising edge.
RESETn  in  1  synchronous, active-low reset.
ps2_clk  in  1  raw PS/2 clock (asynchronous).
ps2_data  in  1  raw PS/2 data (asynchronous).
evt_valid  out  1  FIFO head is valid.
evt_ready  in  1  consumer accepts the head this cycle.
evt_code  out  8  head scan code (prefix bytes stripped).
evt_break  out  1  head is a release event.
evt_ext  out  1  head had an E0 prefix.
fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.
overflow  out  1  sticky flag: an event was dropped because the FIFO was full.
clear_overflow  in  1  clears overflow.
parity_err  out  1  one-cycle pulse on a bad frame (start, parity or stop error).
flush  in  1  empties the FIFO and clears the prefix flags.

Behaviour:
- Reset (RESETn=0 at a CLK edge):
  - FIFO empty; frame FSM in IDLE; ext and brk prefix flags cleared; timeout counter at 0; synchronisers set to 1.
  - Outputs: evt_valid=0, evt_code=0, evt_break=0, evt_ext=0, fifo_count=0, overflow=0, parity_err=0.
  - Reset aborts any frame in progress.
- Edge detection: a falling edge is a synchronised ps2_clk of 1 then 0 in consecutive cycles. ps2_data is sampled from its synchroniser output in the same cycle the edge is detected.
- Frame FSM:
  - IDLE: on an edge, data=0 goes to DATA with the bit index cleared. data=1 is a glitch: stay in IDLE, no error.
  - DATA: shift in LSB first; after the 8th bit go to PARITY.
  - PARITY: capture the bit and go to STOP.
  - STOP: on an edge the frame completes and the FSM returns to IDLE. The frame is good if stop=1 and (XOR of the 8 data bits ^ parity)=1.
  - Bad frame: parity_err pulses in the cycle after the stop edge; no event is formed; prefix flags are cleared.
- Timeout: in any state other than IDLE, the counter increments each cycle with no edge and resets to 0 on an edge. On reaching TIMEOUT_CYCLES the FSM returns to IDLE and the partial frame is discarded. Prefix flags are kept and parity_err is not asserted.
- Decoder, on each good frame:
  - E0 sets ext. F0 sets brk. Neither byte is queued.
  - Any other byte forms event {ext, brk, code}; both flags then clear.
  - Events with brk=1 are pushed only if REPORT_BREAK=1. Otherwise they are discarded and the flags still clear.
- Latency: an event is pushed at the end of the cycle in which the stop edge is detected; evt_valid=1 the next cycle.
- FIFO:
  - evt_valid = (fifo_count != 0). evt_code, evt_break and evt_ext show the head combinationally and read 0 when the FIFO is empty.
  - A pop occurs when evt_valid & evt_ready.
  - Push and pop in the same cycle: both take effect and the count is unchanged. This also holds when full: the push is accepted because a slot frees.
  - Push while full without a pop: the event is dropped and overflow is set the next cycle.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- overflow is set by a drop and cleared by clear_overflow. If both occur in the same cycle, set wins.
- flush: the next cycle fifo_count=0 and both flags are cleared. A push in the same cycle is discarded. The frame FSM is not affected.

Test Plan:
- Frame 0x1C (parity 0, stop 1), evt_ready=0 -> one cycle after the stop edge: evt_valid=1, evt_code=0x1C, break=0, ext=0, fifo_count=1. Assert evt_ready for one cycle -> evt_valid=0, fifo_count=0.
- Frames F0,1C with REPORT_BREAK=0 -> no event, fifo_count stays 0. Same frames with REPORT_BREAK=1 -> one event: code=0x1C, break=1, ext=0.
- Frames E0,F0,75 with REPORT_BREAK=1 -> one event: code=0x75, ext=1, break=1. Then frame 75 -> code=0x75, ext=0, break=0.
- Frame 0x1C with flipped parity -> parity_err high for exactly 1 cycle, no event. Next good 0x32 -> code=0x32.
- FIFO_DEPTH=8, evt_ready=0, 9 good frames 0x15..0x1D -> fifo_count=8, overflow=1. Draining yields 0x15..0x1C in order. clear_overflow -> overflow=0.
- 4 falling edges, then ps2_clk held high for TIMEOUT_CYCLES+10 -> no event, no parity_err. A following full frame 0x24 -> code=0x24.
